// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the 2-way write-back cache.
//   state_e      : controller FSM states
//   line_meta_t  : per-line metadata {valid, dirty, tag}; the tag field is sized to TagMax and
//                  users keep the real tag in its low TAG_W bits, upper bits zero
//   off_w/idx_w/tag_w : byte-address field widths derived from the cache geometry
package cache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmp,
    StWb,
    StAlloc,
    StFill
  } state_e;

  // Packages cannot be parameterised, so the struct carries a wide tag field.
  localparam int unsigned TagMax = 64;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TagMax-1:0] tag;
  } line_meta_t;

  function automatic int unsigned off_w(int unsigned words);
    return $clog2(words) + 2;
  endfunction

  function automatic int unsigned idx_w(int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(int unsigned addr_w, int unsigned words,
                                        int unsigned sets);
    return addr_w - idx_w(sets) - off_w(words);
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: valid/dirty bits (reset), tag and data arrays (not reset).
// Single write port updating a whole line, combinational read.
//   clk, rst            : clock, asynchronous active-low reset (clears valid/dirty)
//   rd_idx              : read set index
//   rd_meta, rd_line    : metadata and data block of the indexed set
//   wr_en, wr_idx       : line write strobe and set index
//   wr_meta, wr_line    : metadata and data block to store
module cache_way_array
  import cache_pkg::*;
#(
  parameter int unsigned SETS   = 256,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned TAG_W  = 20,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output line_meta_t        rd_meta,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  line_meta_t        wr_meta,
  input  logic [LINE_W-1:0] wr_line
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_meta.valid;
      dirty_q[wr_idx] <= wr_meta.dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_meta.tag[TAG_W-1:0];
      data_q[wr_idx] <= wr_line;
    end
  end

  always_comb begin
    rd_meta                 = '0;
    rd_meta.valid           = valid_q[rd_idx];
    rd_meta.dirty           = dirty_q[rd_idx];
    rd_meta.tag[TAG_W-1:0]  = tag_q[rd_idx];
    rd_line                 = data_q[rd_idx];
  end

  logic unused_tag;
  assign unused_tag = ^wr_meta.tag[TagMax-1:TAG_W];

endmodule

// File: rtl/cache_sa_wb.sv
// 2-way set-associative, write-back, write-allocate cache with one LRU bit per set.
// Optional feature macro: CACHE_PERF_CNT_EN adds saturating hit/miss/writeback counters.
//   clk, rst                          : clock, asynchronous active-low reset
//   cpu_req_vld/wen, cpu_addr, cpu_wr_data : CPU request (accepted only when idle)
//   cpu_rd_data, cpu_done             : read word and one-cycle completion pulse
//   mem_req_vld/wen, mem_addr, mem_wr_data : block request to memory, held until mem_req_done
//   mem_rd_data, mem_req_done         : fill block and one-cycle memory completion
//   hit_cnt, miss_cnt, wb_cnt         : event counters (CACHE_PERF_CNT_EN only)
module cache_sa_wb
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned SETS   = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req_vld,
  input  logic                    cpu_req_wen,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wr_data,
  output logic [DATA_W-1:0]       cpu_rd_data,
  output logic                    cpu_done,
  output logic                    mem_req_vld,
  output logic                    mem_req_wen,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [WORDS*DATA_W-1:0] mem_wr_data,
  input  logic [WORDS*DATA_W-1:0] mem_rd_data,
  input  logic                    mem_req_done
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt,
  output logic [31:0]             wb_cnt
`endif
);

  localparam int unsigned OFF_W  = off_w(WORDS);
  localparam int unsigned IDX_W  = idx_w(SETS);
  localparam int unsigned TAG_W  = tag_w(ADDR_W, WORDS, SETS);
  localparam int unsigned LINE_W = WORDS * DATA_W;
  localparam int unsigned WSEL_W = OFF_W - 2;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                victim_q;
  logic                refill_q;  // current CMP follows a fill, so it is not a fresh hit
  logic [SETS-1:0]     lru_q;     // way to evict next

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [WSEL_W-1:0]   req_wsel;
  logic [TagMax-1:0]   req_tag_ext;

  assign req_tag     = addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx     = addr_q[OFF_W +: IDX_W];
  assign req_wsel    = addr_q[2 +: WSEL_W];
  assign req_tag_ext = TagMax'(req_tag);

  line_meta_t        meta0, meta1, wr_meta, victim_meta;
  logic [LINE_W-1:0] line0, line1, wr_line, hit_line, merged_line;
  logic              hit0, hit1, hit, hit_way, victim;
  logic              cmp_wr, fill_wr, wr_en0, wr_en1;
  logic [DATA_W-1:0] rd_word;

  assign hit0    = meta0.valid && (meta0.tag == req_tag_ext);
  assign hit1    = meta1.valid && (meta1.tag == req_tag_ext);
  assign hit     = hit0 || hit1;
  assign hit_way = !hit0;
  assign hit_line = hit_way ? line1 : line0;

  // First invalid way wins, otherwise the LRU way.
  assign victim      = !meta0.valid ? 1'b0 : (!meta1.valid ? 1'b1 : lru_q[req_idx]);
  assign victim_meta = victim ? meta1 : meta0;

  always_comb begin
    merged_line = hit_line;
    rd_word     = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (WSEL_W'(w) == req_wsel) begin
        if (wen_q) merged_line[w*DATA_W +: DATA_W] = wdata_q;
        rd_word = merged_line[w*DATA_W +: DATA_W];
      end
    end
  end

  // Line writes: write hit merges one word and sets dirty; fill installs a clean line.
  // Both happen only in a single cycle, so an abort leaves lines untouched.
  assign cmp_wr  = (state_q == StCmp) && hit && wen_q;
  assign fill_wr = (state_q == StAlloc) && mem_req_vld && mem_req_done;
  assign wr_en0  = (cmp_wr && !hit_way) || (fill_wr && !victim_q);
  assign wr_en1  = (cmp_wr && hit_way) || (fill_wr && victim_q);

  always_comb begin
    wr_meta       = '0;
    wr_meta.valid = 1'b1;
    wr_meta.dirty = !fill_wr;
    wr_meta.tag   = req_tag_ext;
    wr_line       = fill_wr ? mem_rd_data : merged_line;
  end

  cache_way_array #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .LINE_W(LINE_W)
  ) u_way0 (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (req_idx),
    .rd_meta(meta0),
    .rd_line(line0),
    .wr_en  (wr_en0),
    .wr_idx (req_idx),
    .wr_meta(wr_meta),
    .wr_line(wr_line)
  );

  cache_way_array #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .LINE_W(LINE_W)
  ) u_way1 (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (req_idx),
    .rd_meta(meta1),
    .rd_line(line1),
    .wr_en  (wr_en1),
    .wr_idx (req_idx),
    .wr_meta(wr_meta),
    .wr_line(wr_line)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      victim_q    <= 1'b0;
      refill_q    <= 1'b0;
      lru_q       <= '0;
      cpu_rd_data <= '0;
      cpu_done    <= 1'b0;
      mem_req_vld <= 1'b0;
      mem_req_wen <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
`ifdef CACHE_PERF_CNT_EN
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      wb_cnt      <= '0;
`endif
    end else begin
      cpu_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cpu_req_vld) begin
            addr_q   <= cpu_addr;
            wen_q    <= cpu_req_wen;
            wdata_q  <= cpu_wr_data;
            refill_q <= 1'b0;
            state_q  <= StCmp;
          end
        end
        StCmp: begin
          if (hit) begin
            cpu_done       <= 1'b1;
            cpu_rd_data    <= rd_word;
            lru_q[req_idx] <= ~hit_way;
            state_q        <= StIdle;
`ifdef CACHE_PERF_CNT_EN
            if (!refill_q && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
`endif
          end else begin
            victim_q    <= victim;
            mem_req_vld <= 1'b1;
`ifdef CACHE_PERF_CNT_EN
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
`endif
            if (victim_meta.valid && victim_meta.dirty) begin
              mem_req_wen <= 1'b1;
              mem_addr    <= {victim_meta.tag[TAG_W-1:0], req_idx, {OFF_W{1'b0}}};
              mem_wr_data <= victim ? line1 : line0;
              state_q     <= StWb;
            end else begin
              mem_req_wen <= 1'b0;
              mem_addr    <= {req_tag, req_idx, {OFF_W{1'b0}}};
              state_q     <= StAlloc;
            end
          end
        end
        StWb: begin
          if (mem_req_done) begin
            mem_req_vld <= 1'b0;
            mem_req_wen <= 1'b0;
            state_q     <= StAlloc;
`ifdef CACHE_PERF_CNT_EN
            if (wb_cnt != '1) wb_cnt <= wb_cnt + 32'd1;
`endif
          end
        end
        StAlloc: begin
          // Entered from WB with vld low: this gives the idle cycle before the fill read.
          if (!mem_req_vld) begin
            mem_req_vld <= 1'b1;
            mem_req_wen <= 1'b0;
            mem_addr    <= {req_tag, req_idx, {OFF_W{1'b0}}};
          end else if (mem_req_done) begin
            mem_req_vld <= 1'b0;
            state_q     <= StFill;
          end
        end
        StFill: begin
          refill_q <= 1'b1;
          state_q  <= StCmp;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic unused_addr;
  assign unused_addr = ^addr_q[1:0];

endmodule

// File: tb/tb_cache_sa_wb.sv
module tb_cache_sa_wb;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cpu_req_vld = 1'b0;
  logic         cpu_req_wen = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wr_data = '0;
  logic [31:0]  cpu_rd_data;
  logic         cpu_done;
  logic         mem_req_vld;
  logic         mem_req_wen;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wr_data;
  logic [127:0] mem_rd_data = '0;
  logic         mem_req_done = 1'b0;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt, miss_cnt, wb_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]  log_addr  [$];
  logic         log_wen   [$];
  logic [127:0] log_wdata [$];
  longint       log_start [$];
  longint       log_done  [$];

  cache_sa_wb dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req_vld (cpu_req_vld),
    .cpu_req_wen (cpu_req_wen),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_rd_data (cpu_rd_data),
    .cpu_done    (cpu_done),
    .mem_req_vld (mem_req_vld),
    .mem_req_wen (mem_req_wen),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .mem_req_done(mem_req_done)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt),
    .wb_cnt      (wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory image: block at A holds word i = {A[15:12], i+1} in the low byte.
  function automatic logic [127:0] fill_block(input logic [31:0] a);
    logic [127:0] b;
    b = '0;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = {24'h0, a[15:12], 4'(i + 1)};
    return b;
  endfunction

  // Memory responder: logs each request, answers 3 edges later, checks vld drops after done.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_req_vld && rst) begin
        log_addr.push_back(mem_addr);
        log_wen.push_back(mem_req_wen);
        log_wdata.push_back(mem_wr_data);
        log_start.push_back($time);
        repeat (2) @(posedge clk);
        #1;
        if (mem_req_vld) begin
          mem_rd_data  = fill_block(mem_addr);
          mem_req_done = 1'b1;
          @(posedge clk);
          log_done.push_back($time);
          #1;
          mem_req_done = 1'b0;
          check("vld_drop_after_done", {127'b0, mem_req_vld}, 128'd0);
        end
      end
    end
  end

  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                        output logic [31:0] rdata, output int lat);
    cpu_addr    = a;
    cpu_req_wen = w;
    cpu_wr_data = d;
    cpu_req_vld = 1'b1;
    @(posedge clk);
    #1;
    cpu_req_vld = 1'b0;
    lat = 1;
    while (!cpu_done && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("cpu_done_seen", {127'b0, cpu_done}, 128'd1);
    rdata = cpu_rd_data;
  endtask

  task automatic do_reset(input int cycles);
    #1;
    rst = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [31:0] rd;
  int          lat;
  int          base;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_done", {127'b0, cpu_done}, 128'd0);
    check("rst_mem_req_vld", {127'b0, mem_req_vld}, 128'd0);
    check("rst_mem_req_wen", {127'b0, mem_req_wen}, 128'd0);
    check("rst_mem_addr", {96'b0, mem_addr}, 128'd0);
    check("rst_mem_wr_data", mem_wr_data, 128'd0);
    check("rst_cpu_rd_data", {96'b0, cpu_rd_data}, 128'd0);
`ifdef CACHE_PERF_CNT_EN
    check("rst_counters", {32'b0, hit_cnt, miss_cnt, wb_cnt}, 128'd0);
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Cold read miss, then hit
    access(32'h0000_1000, 1'b0, 32'h0, rd, lat);
    check("cold_read_data", {96'b0, rd}, 128'h11);
    check("cold_read_nreq", 128'(log_addr.size()), 128'd1);
    check("cold_read_addr", {96'b0, log_addr[0]}, 128'h1000);
    check("cold_read_wen", {127'b0, log_wen[0]}, 128'd0);
    access(32'h0000_1000, 1'b0, 32'h0, rd, lat);
    check("hit_read_data", {96'b0, rd}, 128'h11);
    check("hit_latency", 128'(lat), 128'd2);
    check("hit_no_mem", 128'(log_addr.size()), 128'd1);
    @(posedge clk);
    #1;
    check("done_one_cycle", {127'b0, cpu_done}, 128'd0);

    // Fresh start, write-allocate miss
    do_reset(2);
    base = log_addr.size();
    access(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, rd, lat);
    check("wmiss_nreq", 128'(log_addr.size() - base), 128'd1);
    check("wmiss_addr", {96'b0, log_addr[base]}, 128'h1000);
    check("wmiss_wen", {127'b0, log_wen[base]}, 128'd0);
`ifdef CACHE_PERF_CNT_EN
    check("refill_hit_not_counted", {96'b0, hit_cnt}, 128'd0);
`endif
    access(32'h0000_1004, 1'b0, 32'h0, rd, lat);
    check("wmiss_readback", {96'b0, rd}, 128'hDEAD_BEEF);
    check("wmiss_readback_lat", 128'(lat), 128'd2);

    // Second way, re-touch way0, then clean eviction of 0x2000
    access(32'h0000_2000, 1'b0, 32'h0, rd, lat);
    check("way1_fill_data", {96'b0, rd}, 128'h21);
    check("way1_fill_addr", {96'b0, log_addr[log_addr.size()-1]}, 128'h2000);
    base = log_addr.size();
    access(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, rd, lat);
    check("whit_lat", 128'(lat), 128'd2);
    check("whit_no_mem", 128'(log_addr.size() - base), 128'd0);
    access(32'h0000_3000, 1'b0, 32'h0, rd, lat);
    check("clean_evict_data", {96'b0, rd}, 128'h31);
    check("clean_evict_nreq", 128'(log_addr.size() - base), 128'd1);
    check("clean_evict_addr", {96'b0, log_addr[base]}, 128'h3000);
    check("clean_evict_wen", {127'b0, log_wen[base]}, 128'd0);

    // Dirty eviction of 0x1000, then fill 0x4000
    base = log_addr.size();
    access(32'h0000_4000, 1'b0, 32'h0, rd, lat);
    check("dirty_evict_data", {96'b0, rd}, 128'h41);
    check("dirty_evict_nreq", 128'(log_addr.size() - base), 128'd2);
    check("wb_addr", {96'b0, log_addr[base]}, 128'h1000);
    check("wb_wen", {127'b0, log_wen[base]}, 128'd1);
    check("wb_data", log_wdata[base], 128'h00000014_00000013_DEADBEEF_00000011);
    check("alloc_addr", {96'b0, log_addr[base+1]}, 128'h4000);
    check("alloc_wen", {127'b0, log_wen[base+1]}, 128'd0);
    check("wb_alloc_gap", 128'(log_start[base+1] - log_done[log_done.size()-2]), 128'd11);

    access(32'h0000_3000, 1'b0, 32'h0, rd, lat);
    check("hit_after_evict", {96'b0, rd}, 128'h31);
    check("hit_after_evict_lat", 128'(lat), 128'd2);
`ifdef CACHE_PERF_CNT_EN
    check("hit_cnt", {96'b0, hit_cnt}, 128'd3);
    check("miss_cnt", {96'b0, miss_cnt}, 128'd4);
    check("wb_cnt", {96'b0, wb_cnt}, 128'd1);
`endif

    // Reset while the 0x5000 fill is outstanding
    cpu_addr    = 32'h0000_5000;
    cpu_req_wen = 1'b0;
    cpu_req_vld = 1'b1;
    @(posedge clk);
    #1;
    cpu_req_vld = 1'b0;
    for (int i = 0; i < 20 && !mem_req_vld; i++) begin
      @(posedge clk);
      #1;
    end
    check("abort_alloc_vld", {127'b0, mem_req_vld}, 128'd1);
    check("abort_alloc_addr", {96'b0, mem_addr}, 128'h5000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_vld_low", {127'b0, mem_req_vld}, 128'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    base = log_addr.size();
    access(32'h0000_1000, 1'b0, 32'h0, rd, lat);
    check("post_rst_miss_nreq", 128'(log_addr.size() - base), 128'd1);
    check("post_rst_miss_addr", {96'b0, log_addr[base]}, 128'h1000);
    check("post_rst_data", {96'b0, rd}, 128'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_sa_wb.md
CACHE_SA_WB -- requirements
Module: cache_sa_wb

Interface
REQ-001 SHALL have parameters: ADDR_W 32, byte-address width; DATA_W 32, CPU word width; WORDS 4, words per block (power of 2); SETS 256, number of sets (power of 2).
REQ-002 SHALL fix associativity at 2 ways, with one LRU bit per set.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 cpu_req_vld  in  1  CPU request valid; cpu_req_wen  in  1  1 = write, 0 = read.
REQ-006 cpu_addr  in  ADDR_W  byte address; cpu_wr_data  in  DATA_W  write word.
REQ-007 cpu_rd_data  out  DATA_W  read word, valid while cpu_done=1; cpu_done  out  1  one-cycle completion pulse.
REQ-008 mem_req_vld  out  1; mem_req_wen  out  1; mem_addr  out  ADDR_W  block-aligned address.
REQ-009 mem_wr_data  out  WORDS*DATA_W  victim block; mem_rd_data  in  WORDS*DATA_W  fill block; mem_req_done  in  1  one-cycle completion.
REQ-010 With CACHE_PERF_CNT_EN defined: hit_cnt, miss_cnt, wb_cnt  out  32  event counters.

Function
REQ-011 Address split SHALL be OFF_W = log2(WORDS)+2 offset bits, IDX_W = log2(SETS) index bits, TAG_W = ADDR_W-IDX_W-OFF_W tag bits; defaults 4/8/20.
REQ-012 Each way line SHALL hold valid, dirty, tag and WORDS data words.
REQ-013 FSM states SHALL be IDLE, CMP, WB, ALLOC, FILL.
REQ-014 IDLE: when cpu_req_vld=1, SHALL latch addr/wen/wr_data and go to CMP; cpu_req_vld SHALL be ignored in all other states.
REQ-015 CMP, hit (valid and tag match in either way): SHALL pulse cpu_done next cycle, set LRU to the other way, return to IDLE; hit latency 2 cycles from acceptance.
REQ-016 Write hit SHALL replace only the addressed word and set dirty; read hit SHALL leave dirty unchanged.
REQ-017 Victim SHALL be the first invalid way (way0 before way1), else the LRU way.
REQ-018 Miss with clean or invalid victim: go to ALLOC, mem_req_vld=1, mem_req_wen=0, mem_addr = {req tag, index, 0}.
REQ-019 Miss with dirty victim: go to WB, mem_req_vld=1, mem_req_wen=1, mem_addr = {victim tag, index, 0}, mem_wr_data = victim block; on mem_req_done go to ALLOC.
REQ-020 mem_req_vld/wen/addr/wr_data SHALL be held stable until the cycle mem_req_done=1; mem_req_vld deasserts the following cycle.
REQ-021 mem_req_done SHALL be ignored outside WB/ALLOC.
REQ-022 ALLOC done -> FILL: victim line written with mem_rd_data, valid=1, new tag, dirty=0.
REQ-023 FILL -> CMP: request re-evaluates as a hit, so write-allocate merge and dirty set happen through REQ-016.
REQ-024 Back-to-back WB then ALLOC SHALL have one idle cycle of mem_req_vld between them.

Reset
REQ-025 On rst low: FSM in IDLE; all valid, dirty and LRU bits cleared; cpu_done, mem_req_vld, mem_req_wen 0; mem_addr, mem_wr_data, cpu_rd_data 0; counters 0.
REQ-026 Data arrays need not reset.
REQ-027 Reset mid-WB/ALLOC SHALL abort the transaction with no partial line update.

Configuration
REQ-028 CACHE_PERF_CNT_EN defined: hit_cnt increments once per CMP hit from IDLE (not the post-FILL re-hit); miss_cnt once per miss; wb_cnt once per WB completion; all saturate at 2^32-1.
REQ-029 CACHE_PERF_CNT_EN undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-030 Package cache_pkg SHALL hold the FSM state enum, OFF_W/IDX_W/TAG_W derivation functions and the line-metadata struct {valid, dirty, tag}.
REQ-031 One sub-module, cache_way_array (one metadata+data array instance per way, single write port, combinational read), SHALL be instantiated twice.

Verification
REQ-032 Read 0x0000_1000 on empty cache, mem returns word0=0x11 -> mem read at 0x1000, cpu_rd_data=0x11; repeat read -> no mem_req_vld, cpu_done 2 cycles after accept.
REQ-033 Write 0x0000_1004=0xDEADBEEF (miss) -> fill from 0x1000, then line dirty, read 0x1004 returns 0xDEADBEEF.
REQ-034 Fill set 0 via 0x1000, 0x2000, write 0x1004, then access 0x3000 -> clean 0x2000 evicted, no WB, single read at 0x3000.
REQ-035 Then access 0x4000 -> WB to 0x1000 with word1=0xDEADBEEF, then read at 0x4000.
REQ-036 Assert rst during ALLOC for 0x5000 -> mem_req_vld=0 immediately; re-read 0x1000 misses (valid cleared).
REQ-037 With CACHE_PERF_CNT_EN, after REQ-032..035 sequence -> hit_cnt, miss_cnt, wb_cnt match scoreboard (wb_cnt=1).
